// File: rtl/iiitb_param_fifo.sv
// Parametrised synchronous FIFO with a level counter, threshold flags, and sticky
// overflow/underflow errors. Read mode is selectable: registered read or first-word-fall-through.
module iiitb_param_fifo #(
  parameter int DATA_WIDTH          = 8,
  parameter int ADDR_WIDTH          = 3,
  parameter int ALMOST_FULL_THRESH  = 6,
  parameter int ALMOST_EMPTY_THRESH = 2,
  parameter int FWFT                = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write_Enable,
  input  logic                  read_Enable,
  input  logic [DATA_WIDTH-1:0] buffer_Input,
  input  logic                  clear_Errors,
  output logic [DATA_WIDTH-1:0] buffer_Output,
  output logic                  output_Valid,
  output logic                  sig_Full,
  output logic                  sig_Empty,
  output logic                  sig_Almost_Full,
  output logic                  sig_Almost_Empty,
  output logic [ADDR_WIDTH:0]   fill_Level,
  output logic                  sig_Overflow,
  output logic                  sig_Underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [ADDR_WIDTH:0]   LVL_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   LVL_AF    = (ADDR_WIDTH+1)'(ALMOST_FULL_THRESH);
  localparam logic [ADDR_WIDTH:0]   LVL_AE    = (ADDR_WIDTH+1)'(ALMOST_EMPTY_THRESH);
  localparam logic [ADDR_WIDTH:0]   LVL_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   level;
  logic                  wr_acc;
  logic                  rd_acc;

  // Every status flag is a pure decode of the level, so flags and level move on the same edge.
  assign fill_Level       = level;
  assign sig_Full         = (level == LVL_DEPTH);
  assign sig_Empty        = (level == '0);
  assign sig_Almost_Full  = (level >= LVL_AF);
  assign sig_Almost_Empty = (level <= LVL_AE);

  // A full FIFO still takes a write when a read frees a slot on the same edge.
  assign rd_acc = read_Enable & ~sig_Empty;
  assign wr_acc = write_Enable & (~sig_Full | rd_acc);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      sig_Overflow  <= 1'b0;
      sig_Underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;

      case ({wr_acc, rd_acc})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase

      // A new error in the clearing cycle must survive, so the set term has priority.
      if (write_Enable && !wr_acc) sig_Overflow <= 1'b1;
      else if (clear_Errors)       sig_Overflow <= 1'b0;

      if (read_Enable && !rd_acc)  sig_Underflow <= 1'b1;
      else if (clear_Errors)       sig_Underflow <= 1'b0;
    end
  end

  // NOTE: the storage array has no reset; the level counter alone decides which entries are live.
  always_ff @(posedge clock) begin
    if (wr_acc) mem[wr_ptr] <= buffer_Input;
  end

  if (FWFT != 0) begin : g_fwft
    assign buffer_Output = mem[rd_ptr];
    assign output_Valid  = ~sig_Empty;
  end else begin : g_registered
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        rd_data  <= '0;
        rd_valid <= 1'b0;
      end else begin
        rd_valid <= rd_acc;
        if (rd_acc) rd_data <= mem[rd_ptr];
      end
    end

    assign buffer_Output = rd_data;
    assign output_Valid  = rd_valid;
  end

endmodule

// File: tb/tb_iiitb_param_fifo.sv
// Bench for iiitb_param_fifo: registered-read and FWFT instances share one stimulus stream and are
// compared each cycle against a queue model, plus hand-computed directed expectations.
module tb_iiitb_param_fifo;

  localparam int DEPTH = 8;
  localparam int AF_TH = 6;
  localparam int AE_TH = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       write_Enable = 1'b0;
  logic       read_Enable = 1'b0;
  logic [7:0] buffer_Input = '0;
  logic       clear_Errors = 1'b0;

  logic [7:0] r_out, f_out;
  logic       r_valid, f_valid;
  logic       r_full, f_full, r_empty, f_empty;
  logic       r_af, f_af, r_ae, f_ae;
  logic [3:0] r_lvl, f_lvl;
  logic       r_ovf, f_ovf, r_udf, f_udf;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  iiitb_param_fifo #(.FWFT(0)) dut_reg (
    .clock(clock), .reset(reset), .write_Enable(write_Enable), .read_Enable(read_Enable),
    .buffer_Input(buffer_Input), .clear_Errors(clear_Errors), .buffer_Output(r_out),
    .output_Valid(r_valid), .sig_Full(r_full), .sig_Empty(r_empty), .sig_Almost_Full(r_af),
    .sig_Almost_Empty(r_ae), .fill_Level(r_lvl), .sig_Overflow(r_ovf), .sig_Underflow(r_udf)
  );

  iiitb_param_fifo #(.FWFT(1)) dut_fwft (
    .clock(clock), .reset(reset), .write_Enable(write_Enable), .read_Enable(read_Enable),
    .buffer_Input(buffer_Input), .clear_Errors(clear_Errors), .buffer_Output(f_out),
    .output_Valid(f_valid), .sig_Full(f_full), .sig_Empty(f_empty), .sig_Almost_Full(f_af),
    .sig_Almost_Empty(f_ae), .fill_Level(f_lvl), .sig_Overflow(f_ovf), .sig_Underflow(f_udf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Model: contents as a queue; registered-read output tracked as last popped word plus a pulse.
  logic [7:0] q[$];
  logic [7:0] m_out;
  logic       m_valid;
  logic       m_ovf;
  logic       m_udf;

  always @(posedge clock or negedge reset) begin
    bit full, empty, rd, wr;
    if (!reset) begin
      q.delete();
      m_out   = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
    end else begin
      full  = (q.size() == DEPTH);
      empty = (q.size() == 0);
      rd    = read_Enable && !empty;
      wr    = write_Enable && (!full || rd);
      m_valid = rd;
      if (rd) m_out = q.pop_front();
      if (wr) q.push_back(buffer_Input);
      if (write_Enable && !wr) m_ovf = 1'b1;
      else if (clear_Errors)   m_ovf = 1'b0;
      if (read_Enable && !rd)  m_udf = 1'b1;
      else if (clear_Errors)   m_udf = 1'b0;
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      check("lvl",     r_lvl,   q.size());
      check("full",    r_full,  q.size() == DEPTH);
      check("empty",   r_empty, q.size() == 0);
      check("afull",   r_af,    q.size() >= AF_TH);
      check("aempty",  r_ae,    q.size() <= AE_TH);
      check("ovf",     r_ovf,   m_ovf);
      check("udf",     r_udf,   m_udf);
      check("r_valid", r_valid, m_valid);
      check("r_out",   r_out,   m_out);
      check("f_lvl",   f_lvl,   q.size());
      check("f_flags", {f_full, f_empty, f_af, f_ae, f_ovf, f_udf},
            {q.size() == DEPTH, q.size() == 0, q.size() >= AF_TH, q.size() <= AE_TH, m_ovf, m_udf});
      check("f_valid", f_valid, q.size() != 0);
      if (q.size() != 0) check("f_out", f_out, q[0]);
    end
  end

  task automatic step(input logic we, input logic re, input logic [7:0] d, input logic clr);
    write_Enable = we;
    read_Enable  = re;
    buffer_Input = d;
    clear_Errors = clr;
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_lvl"},   r_lvl,   0);
    check({tag, "_empty"}, r_empty, 1);
    check({tag, "_aempty"}, r_ae,   1);
    check({tag, "_full"},  r_full,  0);
    check({tag, "_afull"}, r_af,    0);
    check({tag, "_valid"}, r_valid, 0);
    check({tag, "_out"},   r_out,   0);
    check({tag, "_err"},   {r_ovf, r_udf}, 0);
    check({tag, "_fvalid"}, f_valid, 0);
  endtask

  initial begin
    #1 reset = 1'b0;
    #2 check_reset_state("rst");
    @(negedge clock);
    #2 reset = 1'b1;

    // Fill with 0x01..0x08; almost-full at level 6, full at 8.
    for (int i = 1; i <= 8; i++) begin
      step(1, 0, 8'(i), 0);
      check("fill_lvl", r_lvl, i);
      check("fill_af", r_af, i >= 6);
      check("fill_full", r_full, i == 8);
    end
    check("fwft_head", f_out, 8'h01);

    step(1, 0, 8'hFF, 0);
    check("ovf_set", r_ovf, 1);
    check("ovf_lvl", r_lvl, 8);
    step(0, 0, 8'h00, 1);
    check("ovf_clr", r_ovf, 0);

    // Full with both enables: pass-through, level pinned at 8.
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 8'hA0 + 8'(i), 0);
      check("pass_lvl", r_lvl, 8);
      check("pass_out", r_out, 8'(i + 1));
      check("pass_valid", r_valid, 1);
      check("pass_ovf", r_ovf, 0);
    end

    // Drain: 0x04..0x08 then the wrapped words 0xA0..0xA2.
    for (int i = 0; i < 8; i++) begin
      logic [7:0] exp_d;
      exp_d = (i < 5) ? 8'(i + 4) : 8'hA0 + 8'(i - 5);
      step(0, 1, 8'h00, 0);
      check("drain_out", r_out, exp_d);
      check("drain_valid", r_valid, 1);
    end
    step(0, 0, 8'h00, 0);
    check("drain_pulse_end", r_valid, 0);
    check("drain_empty", r_empty, 1);

    // Empty with both enables: write accepted, read rejected.
    step(1, 1, 8'h5A, 0);
    check("eb_lvl", r_lvl, 1);
    check("eb_udf", r_udf, 1);
    check("eb_valid", r_valid, 0);
    step(0, 0, 8'h00, 1);
    check("udf_clr", r_udf, 0);
    step(0, 1, 8'h00, 0);
    check("eb_read", r_out, 8'h5A);
    check("eb_read_valid", r_valid, 1);
    step(0, 1, 8'h00, 1);
    check("udf_set_wins", r_udf, 1);
    step(0, 0, 8'h00, 1);
    check("udf_clr2", r_udf, 0);

    // Reset mid-stream at level 5, asserted between edges.
    for (int i = 0; i < 5; i++) step(1, 0, 8'h31 + 8'(i), 0);
    step(0, 0, 8'h00, 0);
    check("pre_rst_lvl", r_lvl, 5);
    @(negedge clock);
    #2 reset = 1'b0;
    #1 check_reset_state("mid_rst");
    @(negedge clock);
    #2 reset = 1'b1;
    step(1, 0, 8'h77, 0);
    step(0, 1, 8'h00, 0);
    check("post_rst_out", r_out, 8'h77);
    check("post_rst_lvl", r_lvl, 0);
    step(0, 0, 8'h00, 0);

    // FWFT presentation without a read request.
    step(1, 0, 8'h11, 0);
    check("fwft_valid1", f_valid, 1);
    check("fwft_out1", f_out, 8'h11);
    step(1, 0, 8'h22, 0);
    check("fwft_hold", f_out, 8'h11);
    step(0, 1, 8'h00, 0);
    check("fwft_out2", f_out, 8'h22);
    check("fwft_valid2", f_valid, 1);
    step(0, 1, 8'h00, 0);
    check("fwft_drained", f_valid, 0);
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
